// File: rtl/tri_bus_port_ctrl.sv
// Controller for one end of a shared half-duplex tri-state bus: sequences write drive,
// read strobe and turnaround for one valid/ready request at a time.
module tri_bus_port_ctrl #(
   parameter int N         = 8,
   parameter int WR_CYCLES = 2,
   parameter int RD_CYCLES = 2,
   parameter int TA_CYCLES = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid_i,
   output logic         req_ready_o,
   input  logic         req_we_i,
   input  logic [N-1:0] req_wdata_i,
   output logic         rsp_valid_o,
   output logic [N-1:0] rsp_rdata_o,
   output logic         busy_o,
   inout  wire  [N-1:0] bus_io,
   output logic         bus_cs_o,
   output logic         bus_we_o,
   output logic         bus_re_o
);

   localparam int MAX_RW  = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
   localparam int MAX_CYC = (MAX_RW > TA_CYCLES) ? MAX_RW : TA_CYCLES;
   localparam int CW      = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

   // Counter is loaded with (cycles - 1) on state entry and the state exits when it reaches zero.
   localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYCLES - 1);
   localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYCLES - 1);
   localparam logic [CW-1:0] TA_LOAD = CW'((TA_CYCLES > 0) ? TA_CYCLES - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ,
      S_TURN,
      S_DONE
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    wdata_q, wdata_d;
   logic [N-1:0]    rdata_q, rdata_d;
   logic            oe_q, cs_q, we_q, re_q, rsp_valid_q;
   logic            cnt_zero;
   state_e          after_op;
   logic [CW-1:0]   after_op_load;

   assign cnt_zero      = (cnt_q == '0);
   assign after_op      = (TA_CYCLES > 0) ? S_TURN : S_DONE;
   assign after_op_load = (TA_CYCLES > 0) ? TA_LOAD : '0;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               wdata_d = req_wdata_i;
               if (req_we_i) begin
                  state_d = S_WRITE;
                  cnt_d   = WR_LOAD;
               end else begin
                  state_d = S_READ;
                  cnt_d   = RD_LOAD;
               end
            end
         end
         S_WRITE: begin
            if (cnt_zero) begin
               state_d = after_op;
               cnt_d   = after_op_load;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_READ: begin
            if (cnt_zero) begin
               rdata_d = bus_io;
               state_d = after_op;
               cnt_d   = after_op_load;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_TURN: begin
            if (cnt_zero) begin
               state_d = S_DONE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Bus-side outputs are decoded from the next state so they change on the same edge as the state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         oe_q        <= 1'b0;
         cs_q        <= 1'b0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         oe_q        <= (state_d == S_WRITE);
         cs_q        <= (state_d == S_WRITE) || (state_d == S_READ);
         we_q        <= (state_d == S_WRITE);
         re_q        <= (state_d == S_READ);
         rsp_valid_q <= (state_d == S_DONE);
      end
   end

   assign bus_io      = oe_q ? wdata_q : 'z;
   assign req_ready_o = (state_q == S_IDLE);
   assign busy_o      = (state_q != S_IDLE);
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rdata_q;
   assign bus_cs_o    = cs_q;
   assign bus_we_o    = we_q;
   assign bus_re_o    = re_q;

endmodule

// File: tb/tb_tri_bus_port_ctrl.sv
// Directed bench for tri_bus_port_ctrl: default instance plus a TA=0/RD=1 instance.
// Both buses carry pull-ups, so a released bus reads 8'hFF.
module tb_tri_bus_port_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   int         errors = 0;
   int         checks = 0;

   logic       req_valid, req_we, req_ready, rsp_valid, busy, bus_cs, bus_we, bus_re;
   logic [7:0] req_wdata, rsp_rdata, peer_data;
   wire  [7:0] bus;

   logic       req2_valid, req2_we, req2_ready, rsp2_valid, busy2, bus2_cs, bus2_we, bus2_re;
   logic [7:0] req2_wdata, rsp2_rdata;
   wire  [7:0] bus2;

   always #5 clk = ~clk;

   pullup pu_bus  (bus);
   pullup pu_bus2 (bus2);

   // Peer ends drive the bus only while the read strobe is high.
   assign bus  = bus_re  ? peer_data : 8'bz;
   assign bus2 = bus2_re ? 8'h81     : 8'bz;

   tri_bus_port_ctrl dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we), .req_wdata_i(req_wdata),
      .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .busy_o(busy),
      .bus_io(bus), .bus_cs_o(bus_cs), .bus_we_o(bus_we), .bus_re_o(bus_re)
   );

   tri_bus_port_ctrl #(.N(8), .WR_CYCLES(2), .RD_CYCLES(1), .TA_CYCLES(0)) dut2 (
      .clk(clk), .reset(reset),
      .req_valid_i(req2_valid), .req_ready_o(req2_ready), .req_we_i(req2_we), .req_wdata_i(req2_wdata),
      .rsp_valid_o(rsp2_valid), .rsp_rdata_o(rsp2_rdata), .busy_o(busy2),
      .bus_io(bus2), .bus_cs_o(bus2_cs), .bus_we_o(bus2_we), .bus_re_o(bus2_re)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int first_re, we_fell, gap, overlap, rsp_cnt;

      reset = 1'b1;
      req_valid = 0; req_we = 0; req_wdata = '0; peer_data = '0;
      req2_valid = 0; req2_we = 0; req2_wdata = '0;

      // Reset held three cycles
      repeat (3) tick();
      check("rst_bus_z",     bus, 8'hFF);
      check("rst_req_ready", req_ready, 1);
      check("rst_busy",      busy, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 8'h00);
      check("rst_cs",        bus_cs, 0);
      reset = 1'b0;
      tick();
      check("idle_req_ready", req_ready, 1);

      // Write 8'hA5
      req_valid = 1; req_we = 1; req_wdata = 8'hA5;
      tick();
      req_valid = 0;
      check("wr1_bus",   bus, 8'hA5);
      check("wr1_cs",    bus_cs, 1);
      check("wr1_we",    bus_we, 1);
      check("wr1_re",    bus_re, 0);
      check("wr1_ready", req_ready, 0);
      check("wr1_busy",  busy, 1);
      tick();
      check("wr2_bus",   bus, 8'hA5);
      check("wr2_we",    bus_we, 1);
      tick();
      check("wr_ta_bus", bus, 8'hFF);
      check("wr_ta_we",  bus_we, 0);
      check("wr_ta_cs",  bus_cs, 0);
      check("wr_ta_rsp", rsp_valid, 0);
      tick();
      check("wr_done_rsp",   rsp_valid, 1);
      check("wr_done_ready", req_ready, 0);
      tick();
      check("wr_idle_rsp",   rsp_valid, 0);
      check("wr_idle_ready", req_ready, 1);
      check("wr_idle_busy",  busy, 0);

      // Read, peer drives 8'h3C
      peer_data = 8'h3C;
      req_valid = 1; req_we = 0;
      tick();
      req_valid = 0;
      check("rd1_re",  bus_re, 1);
      check("rd1_cs",  bus_cs, 1);
      check("rd1_we",  bus_we, 0);
      check("rd1_bus", bus, 8'h3C);
      tick();
      check("rd2_re",  bus_re, 1);
      tick();
      check("rd_ta_re",    bus_re, 0);
      check("rd_ta_rdata", rsp_rdata, 8'h3C);
      check("rd_ta_rsp",   rsp_valid, 0);
      tick();
      check("rd_done_rsp",   rsp_valid, 1);
      check("rd_done_rdata", rsp_rdata, 8'h3C);
      tick();
      check("rd_idle_rsp",   rsp_valid, 0);
      check("rd_hold_rdata", rsp_rdata, 8'h3C);

      // Write 8'hFF then read with req_valid held
      peer_data = 8'h5A;
      req_valid = 1; req_we = 1; req_wdata = 8'hFF;
      tick();
      req_we = 0;
      first_re = -1; we_fell = 0; gap = 0; overlap = 0; rsp_cnt = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (bus_we && bus_re) overlap++;
         if (rsp_valid) rsp_cnt++;
         if (!bus_we) we_fell = 1;
         if (bus_re && first_re < 0) begin
            first_re  = i;
            req_valid = 0;
         end
         if (we_fell != 0 && first_re < 0 && !bus_we && !bus_re) gap++;
      end
      req_valid = 0;
      check("b2b_accept_gap", first_re, 5);
      check("b2b_ta_gap",     gap, 3);
      check("b2b_overlap",    overlap, 0);
      check("b2b_rsp_count",  rsp_cnt, 2);
      check("b2b_rdata",      rsp_rdata, 8'h5A);

      // Reset asserted during the second WRITE cycle
      req_valid = 1; req_we = 1; req_wdata = 8'h33;
      tick();
      req_valid = 0;
      check("mid_wr1_bus", bus, 8'h33);
      tick();
      check("mid_wr2_we", bus_we, 1);
      reset = 1'b1;
      tick();
      check("mid_rst_bus",   bus, 8'hFF);
      check("mid_rst_rsp",   rsp_valid, 0);
      check("mid_rst_busy",  busy, 0);
      check("mid_rst_ready", req_ready, 1);
      check("mid_rst_cs",    bus_cs, 0);
      check("mid_rst_rdata", rsp_rdata, 8'h00);
      reset = 1'b0;
      rsp_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (rsp_valid) rsp_cnt++;
      end
      check("mid_rst_no_rsp", rsp_cnt, 0);

      // TA_CYCLES=0, RD_CYCLES=1 read of 8'h81
      req2_valid = 1; req2_we = 0;
      tick();
      req2_valid = 0;
      check("ta0_re",  bus2_re, 1);
      check("ta0_rsp_early", rsp2_valid, 0);
      tick();
      check("ta0_rsp",   rsp2_valid, 1);
      check("ta0_rdata", rsp2_rdata, 8'h81);
      check("ta0_re_off", bus2_re, 0);
      tick();
      check("ta0_rsp_off", rsp2_valid, 0);
      check("ta0_ready",   req2_ready, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
